// File: rtl/splitter.sv
// Splits a 6-bit unsigned value into two BCD digits (tens, units) with one
// register stage, and flags values above MAX_VALUE.
module splitter #(
    parameter int MAX_VALUE = 59
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] number_i,
    input  logic       valid_i,
    output logic [3:0] left_digit_o,
    output logic [3:0] right_digit_o,
    output logic       valid_o,
    output logic       range_err_o
);

    localparam logic [5:0] MAX_V = 6'(MAX_VALUE);

    logic [3:0] left_p0;
    logic [3:0] right_p0;
    logic       err_p0;
    logic       vld_p0;
    logic [3:0] tens;
    logic [3:0] units;

    // Constant-divisor split: a threshold ladder picks the tens digit and a
    // single constant subtraction leaves the units digit.
    function automatic logic [3:0] tens_of(input logic [5:0] n);
        logic [3:0] t;
        if (n >= 6'd60)      t = 4'd6;
        else if (n >= 6'd50) t = 4'd5;
        else if (n >= 6'd40) t = 4'd4;
        else if (n >= 6'd30) t = 4'd3;
        else if (n >= 6'd20) t = 4'd2;
        else if (n >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] n, input logic [3:0] t);
        logic [5:0] rem;
        rem = n - (6'(t) * 6'd10);
        return rem[3:0];
    endfunction

    always_comb begin
        tens  = tens_of(number_i);
        units = units_of(number_i, tens);
    end

    // Stage p0: output registers; digits and range flag hold when valid_i is low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            left_p0  <= 4'd0;
            right_p0 <= 4'd0;
            err_p0   <= 1'b0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= valid_i;
            if (valid_i) begin
                left_p0  <= tens;
                right_p0 <= units;
                err_p0   <= (number_i > MAX_V);
            end
        end
    end

    assign left_digit_o  = left_p0;
    assign right_digit_o = right_p0;
    assign valid_o       = vld_p0;
    assign range_err_o   = err_p0;

endmodule

// File: tb/tb_splitter.sv
// Scoreboard bench for splitter: stimulus pushes expected {tens, units, err},
// monitors pop and compare whenever valid_o is high.
module tb_splitter;

    logic       clk;
    logic       rst;
    logic [5:0] number;
    logic       valid;
    logic [3:0] left_d;
    logic [3:0] right_d;
    logic       vld_out;
    logic       err_out;

    logic [5:0] number23;
    logic       valid23;
    logic [3:0] left23;
    logic [3:0] right23;
    logic       vld23;
    logic       err23;

    logic [8:0] exp_q[$];
    logic [8:0] exp23_q[$];

    int passed;
    int total;

    splitter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .number_i     (number),
        .valid_i      (valid),
        .left_digit_o (left_d),
        .right_digit_o(right_d),
        .valid_o      (vld_out),
        .range_err_o  (err_out)
    );

    splitter #(.MAX_VALUE(23)) dut23 (
        .clk_i        (clk),
        .rst_i        (rst),
        .number_i     (number23),
        .valid_i      (valid23),
        .left_digit_o (left23),
        .right_digit_o(right23),
        .valid_o      (vld23),
        .range_err_o  (err23)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic send(input logic [5:0] n, input logic [8:0] exp);
        @(negedge clk);
        number = n;
        valid  = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (vld_out) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_out: got %h, expected no output", {left_d, right_d, err_out});
            end else begin
                check("split", {1'b0, left_d, right_d, err_out}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (vld23) begin
            if (exp23_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_out23: got %h, expected no output", {left23, right23, err23});
            end else begin
                check("split_max23", {1'b0, left23, right23, err23}, {1'b0, exp23_q.pop_front()});
            end
        end
    end

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b0;
        valid    = 1'b0;
        number   = 6'd0;
        valid23  = 1'b0;
        number23 = 6'd0;

        #2;
        check("reset_state", {1'b0, left_d, right_d, err_out, vld_out}, 10'd0);
        @(negedge clk);
        rst = 1'b1;

        // Hand-computed boundary vectors, back-to-back
        send(6'd0,  {4'd0, 4'd0, 1'b0});
        send(6'd9,  {4'd0, 4'd9, 1'b0});
        send(6'd10, {4'd1, 4'd0, 1'b0});
        send(6'd59, {4'd5, 4'd9, 1'b0});
        send(6'd60, {4'd6, 4'd0, 1'b1});
        send(6'd63, {4'd6, 4'd3, 1'b1});
        send(6'd37, {4'd3, 4'd7, 1'b0});
        idle();

        for (int n = 0; n < 64; n++) begin
            send(6'(n), {4'(n / 10), 4'(n % 10), (n >= 60)});
        end
        idle();

        // Hold: outputs keep 4,7 while valid_i is low
        send(6'd47, {4'd4, 4'd7, 1'b0});
        @(negedge clk);
        valid  = 1'b0;
        number = 6'd12;
        repeat (5) begin
            @(posedge clk);
            #2;
            check("hold", {1'b0, left_d, right_d, err_out, vld_out}, {1'b0, 4'd4, 4'd7, 1'b0, 1'b0});
        end

        // Asynchronous reset between edges
        send(6'd23, {4'd2, 4'd3, 1'b0});
        @(posedge clk);
        #2;
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        check("async_rst", {1'b0, left_d, right_d, err_out, vld_out}, 10'd0);
        @(negedge clk);
        rst = 1'b1;
        send(6'd5, {4'd0, 4'd5, 1'b0});
        idle();

        // Reset on the same cycle as a sample: the sample must vanish
        @(negedge clk);
        number = 6'd58;
        valid  = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            check("mid_rst", {1'b0, left_d, right_d, err_out, vld_out}, 10'd0);
        end

        // MAX_VALUE = 23 instance
        @(negedge clk);
        number23 = 6'd23;
        valid23  = 1'b1;
        exp23_q.push_back({4'd2, 4'd3, 1'b0});
        @(negedge clk);
        number23 = 6'd24;
        exp23_q.push_back({4'd2, 4'd4, 1'b1});
        @(negedge clk);
        valid23 = 1'b0;

        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp23_q.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0 || exp23_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d/%0d results outstanding, expected 0/0", exp_q.size(), exp23_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
